// File: rtl/queue_uart_tx.sv
// ---------------------------------------------------------------------------
// queue_uart_tx
//
// Drains an upstream queue one word at a time and sends each word as an
// asynchronous serial frame: a start bit (0), WIDTH data bits LSB first, an
// optional even-parity bit, and a stop bit (1). Every bit lasts CLKS_PER_BIT
// clocks. While the queue holds data and enable stays high, frames go out
// back-to-back. Consecutive frames are separated by two idle-high cycles,
// which are the POP and LOAD states.
//
// Optional feature:
//   QUEUE_UART_TX_PARITY_EN  when defined, a PARITY bit (XOR of the data
//                            bits) is inserted between the data bits and STOP.
//
// Parameters:
//   WIDTH         data bits per frame; must match the queue word width
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//
// Ports:
//   clk         system clock; all state changes on posedge
//   rst_n       asynchronous reset, active-low; abandons any frame in flight
//   enable      1 = may start new frames (a frame in flight always completes)
//   q_empty     queue empty flag
//   q_data      queue output word; valid the cycle after a dequeue pulse
//   dequeue     registered single-cycle pop request to the queue
//   tx          registered serial line; idles high
//   busy        1 whenever not IDLE (POP through the end of STOP)
//   frame_done  1-cycle pulse on the last cycle of STOP
// ---------------------------------------------------------------------------
module queue_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             q_empty,
    input  logic [WIDTH-1:0] q_data,
    output logic             dequeue,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
`ifdef QUEUE_UART_TX_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud;
    logic [CNT_W-1:0] baud_next;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] bit_idx_next;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_next;
    logic             tx_next;
    logic             dequeue_next;
    logic             bit_done;
    logic             can_start;
`ifdef QUEUE_UART_TX_PARITY_EN
    logic             parity;
    logic             parity_next;
`endif

    assign bit_done   = (baud == LAST_CNT);
    assign can_start  = enable && !q_empty;
    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && bit_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            dequeue <= 1'b0;
`ifdef QUEUE_UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
            dequeue <= dequeue_next;
`ifdef QUEUE_UART_TX_PARITY_EN
            parity  <= parity_next;
`endif
        end
    end

    // Next-state logic. The baud counter runs only inside the serial states
    // and is cleared on every bit boundary, so each bit is exactly
    // CLKS_PER_BIT cycles regardless of which state follows.
    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
`ifdef QUEUE_UART_TX_PARITY_EN
        parity_next  = parity;
`endif
        case (state)
            IDLE: begin
                if (can_start) begin
                    state_next = POP;
                end
            end
            POP: begin
                state_next = LOAD;
            end
            LOAD: begin
                // q_data is valid now, one cycle after the dequeue pulse.
                shift_next   = q_data;
`ifdef QUEUE_UART_TX_PARITY_EN
                parity_next  = ^q_data;
`endif
                baud_next    = '0;
                bit_idx_next = '0;
                state_next   = START;
            end
            START: begin
                if (bit_done) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_next  = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == LAST_IDX) begin
                        bit_idx_next = '0;
`ifdef QUEUE_UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
`ifdef QUEUE_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    baud_next  = '0;
                    state_next = can_start ? POP : IDLE;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the state being entered, so tx
    // and dequeue line up with the state they belong to and tx only moves
    // on bit boundaries.
    always_comb begin
        tx_next      = 1'b1;
        dequeue_next = (state_next == POP);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef QUEUE_UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

endmodule
